i2c_reg_seq: RTL

//  Hardware command sequencer driving the cmd/ws/stat port of i2c_master; replaces the hand-driven

---
 rtl/i2c_reg_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_seq.sv
// ---------------------------------------------------------------------------
// i2c_reg_seq
//
// Hardware command sequencer for the cmd/ws/stat port of i2c_master. One
// accepted request runs one indexed register transaction on the bus:
//   write : START|WRITE {addr,0}, WRITE idx, WRITE data x len (last |STOP)
//   read  : START|WRITE {addr,0}, WRITE idx, START|WRITE {addr,1},
//           READ x len (last READ|NACK|STOP, len==0 behaves as len==1)
// A master error aborts with CLRS followed by STOP. An optional per-command
// timeout aborts without issuing anything further.
//
// Ports
//   clk, aresetn              clock, synchronous active-low reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_rnw, req_addr,        request fields, latched when accepted
//   req_idx, req_len
//   wr_data/wr_valid/wr_ready write byte stream (consumed when valid & ready)
//   rd_data/rd_valid          read byte stream (one-cycle pulse per byte)
//   done/err/err_stat         end-of-transaction pulse, abort flag and the
//                             master status captured at abort (0 on timeout)
//   m_cmd/m_dat/m_ws          command, data and one-cycle strobe to master
//   m_stat/m_dat_in           status and read data from master
// ---------------------------------------------------------------------------

// Command and status encodings shared with i2c_master.
`ifndef C_SZ
`define C_SZ   6
`define C_STRT 6'h01
`define C_STOP 6'h02
`define C_WRTE 6'h04
`define C_READ 6'h08
`define C_NACK 6'h10
`define C_CLRS 6'h20
`endif

`ifndef S_SZ
`define S_SZ   4
`define SB_DON 0
`define SB_ERR 1
`endif

module i2c_reg_seq #(
  parameter int LEN_W = 4,
  parameter int TMO_W = 16,
  parameter int TMO   = 0
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rnw,
  input  logic [6:0]        req_addr,
  input  logic [7:0]        req_idx,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [`S_SZ-1:0]  err_stat,
  output logic [`C_SZ-1:0]  m_cmd,
  output logic [7:0]        m_dat,
  output logic              m_ws,
  input  logic [`S_SZ-1:0]  m_stat,
  input  logic [7:0]        m_dat_in
);

  // Last WAIT count before the timeout fires; counter runs from the strobe.
  localparam logic [TMO_W-1:0] TMO_LAST = (TMO > 0) ? TMO_W'(TMO - 1) : {TMO_W{1'b0}};

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ISSUE = 4'd1,
    ST_ARM   = 4'd2,
    ST_WAIT  = 4'd3,
    ST_NEXT  = 4'd4,
    ST_FETCH = 4'd5,
    ST_FIN   = 4'd6,
    ST_CLR   = 4'd7,
    ST_ESTP  = 4'd8
  } state_t;

  // Which command the shared ARM/WAIT states are waiting on.
  typedef enum logic [1:0] {
    PH_RUN  = 2'd0,
    PH_CLR  = 2'd1,
    PH_ESTP = 2'd2
  } phase_t;

  // Position within the transaction.
  localparam logic [1:0] STEP_AW   = 2'd0;  // address + W
  localparam logic [1:0] STEP_IDX  = 2'd1;  // register index
  localparam logic [1:0] STEP_AR   = 2'd2;  // repeated start, address + R
  localparam logic [1:0] STEP_DATA = 2'd3;  // data bytes

  state_t             state_r;
  phase_t             phase_r;
  logic [1:0]         step_r;
  logic               rnw_r;
  logic [6:0]         addr_r;
  logic [7:0]         idx_r;
  logic [LEN_W-1:0]   cnt_r;
  logic [TMO_W-1:0]   tmo_r;
  logic               req_ready_r;
  logic               wr_ready_r;
  logic [7:0]         rd_data_r;
  logic               rd_valid_r;
  logic               done_r;
  logic               err_r;
  logic [`S_SZ-1:0]   err_stat_r;
  logic [`C_SZ-1:0]   m_cmd_r;
  logic [7:0]         m_dat_r;
  logic               m_ws_r;
  logic               tmo_hit_s;
  logic               cnt_one_s;
  logic               cnt_two_s;

  // Data-phase command; the final byte closes the transaction.
  function automatic logic [`C_SZ-1:0] data_cmd(input logic rnw, input logic last);
    logic [`C_SZ-1:0] c;
    if (rnw) begin
      c = `C_READ;
      if (last) begin
        c = c | `C_NACK | `C_STOP;
      end else begin
        c = c;
      end
    end else begin
      c = `C_WRTE;
      if (last) begin
        c = c | `C_STOP;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  assign tmo_hit_s = (TMO > 0) && (tmo_r >= TMO_LAST);
  assign cnt_one_s = (cnt_r == LEN_W'(1));
  assign cnt_two_s = (cnt_r == LEN_W'(2));

  assign req_ready = req_ready_r;
  assign wr_ready  = wr_ready_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign done      = done_r;
  assign err       = err_r;
  assign err_stat  = err_stat_r;
  assign m_cmd     = m_cmd_r;
  assign m_dat     = m_dat_r;
  assign m_ws      = m_ws_r;

  // Sequencer: request acceptance, command issue, status wait, abort paths.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      phase_r     <= PH_RUN;
      step_r      <= STEP_AW;
      rnw_r       <= 1'b0;
      addr_r      <= 7'd0;
      idx_r       <= 8'd0;
      cnt_r       <= {LEN_W{1'b0}};
      tmo_r       <= {TMO_W{1'b0}};
      req_ready_r <= 1'b1;
      wr_ready_r  <= 1'b0;
      rd_data_r   <= 8'd0;
      rd_valid_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_stat_r  <= {`S_SZ{1'b0}};
      m_cmd_r     <= {`C_SZ{1'b0}};
      m_dat_r     <= 8'd0;
      m_ws_r      <= 1'b0;
    end else begin
      // Pulses default low; strobe-to-status counter runs while a command
      // is outstanding and is cleared again wherever a new strobe is raised.
      m_ws_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      if (state_r == ST_ISSUE || state_r == ST_CLR || state_r == ST_ESTP ||
          state_r == ST_ARM   || state_r == ST_WAIT) begin
        tmo_r <= tmo_r + TMO_W'(1);
      end else begin
        tmo_r <= tmo_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready_r) begin
            rnw_r       <= req_rnw;
            addr_r      <= req_addr;
            idx_r       <= req_idx;
            // A zero-length read still has to fetch one byte to end with NACK.
            cnt_r       <= (req_rnw && (req_len == {LEN_W{1'b0}})) ? LEN_W'(1) : req_len;
            req_ready_r <= 1'b0;
            err_stat_r  <= {`S_SZ{1'b0}};
            phase_r     <= PH_RUN;
            step_r      <= STEP_AW;
            m_cmd_r     <= `C_STRT | `C_WRTE;
            m_dat_r     <= {req_addr, 1'b0};
            m_ws_r      <= 1'b1;
            tmo_r       <= {TMO_W{1'b0}};
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ISSUE, ST_CLR, ST_ESTP: begin
          state_r <= ST_ARM;
        end

        // Status from the previous command may still be visible here.
        ST_ARM: begin
          state_r <= ST_WAIT;
        end

        ST_WAIT: begin
          case (phase_r)
            PH_RUN: begin
              if (m_stat[`SB_ERR]) begin
                err_stat_r <= m_stat;
                m_cmd_r    <= `C_CLRS;
                m_ws_r     <= 1'b1;
                tmo_r      <= {TMO_W{1'b0}};
                phase_r    <= PH_CLR;
                state_r    <= ST_CLR;
              end else if (m_stat[`SB_DON]) begin
                state_r <= ST_NEXT;
              end else if (tmo_hit_s) begin
                done_r     <= 1'b1;
                err_r      <= 1'b1;
                err_stat_r <= {`S_SZ{1'b0}};
                state_r    <= ST_FIN;
              end else begin
                state_r <= ST_WAIT;
              end
            end
            PH_CLR: begin
              if (m_stat[`SB_DON]) begin
                m_cmd_r <= `C_STOP;
                m_ws_r  <= 1'b1;
                tmo_r   <= {TMO_W{1'b0}};
                phase_r <= PH_ESTP;
                state_r <= ST_ESTP;
              end else if (tmo_hit_s) begin
                done_r     <= 1'b1;
                err_r      <= 1'b1;
                err_stat_r <= {`S_SZ{1'b0}};
                state_r    <= ST_FIN;
              end else begin
                state_r <= ST_WAIT;
              end
            end
            PH_ESTP: begin
              // A second error while stopping is not reported; the bus is
              // being released either way.
              if (m_stat[`SB_DON]) begin
                done_r  <= 1'b1;
                err_r   <= 1'b1;
                state_r <= ST_FIN;
              end else if (tmo_hit_s) begin
                done_r     <= 1'b1;
                err_r      <= 1'b1;
                err_stat_r <= {`S_SZ{1'b0}};
                state_r    <= ST_FIN;
              end else begin
                state_r <= ST_WAIT;
              end
            end
            default: begin
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              state_r <= ST_FIN;
            end
          endcase
        end

        ST_NEXT: begin
          case (step_r)
            STEP_AW: begin
              // Zero-length write ends right after the index byte.
              m_cmd_r <= (!rnw_r && (cnt_r == {LEN_W{1'b0}})) ? (`C_WRTE | `C_STOP) : `C_WRTE;
              m_dat_r <= idx_r;
              m_ws_r  <= 1'b1;
              tmo_r   <= {TMO_W{1'b0}};
              step_r  <= STEP_IDX;
              state_r <= ST_ISSUE;
            end
            STEP_IDX: begin
              if (rnw_r) begin
                m_cmd_r <= `C_STRT | `C_WRTE;
                m_dat_r <= {addr_r, 1'b1};
                m_ws_r  <= 1'b1;
                tmo_r   <= {TMO_W{1'b0}};
                step_r  <= STEP_AR;
                state_r <= ST_ISSUE;
              end else if (cnt_r == {LEN_W{1'b0}}) begin
                done_r  <= 1'b1;
                state_r <= ST_FIN;
              end else begin
                wr_ready_r <= 1'b1;
                step_r     <= STEP_DATA;
                state_r    <= ST_FETCH;
              end
            end
            STEP_AR: begin
              m_cmd_r <= data_cmd(1'b1, cnt_one_s);
              m_dat_r <= 8'd0;
              m_ws_r  <= 1'b1;
              tmo_r   <= {TMO_W{1'b0}};
              step_r  <= STEP_DATA;
              state_r <= ST_ISSUE;
            end
            STEP_DATA: begin
              cnt_r <= cnt_r - LEN_W'(1);
              if (rnw_r) begin
                rd_data_r  <= m_dat_in;
                rd_valid_r <= 1'b1;
              end else begin
                rd_valid_r <= 1'b0;
              end
              if (cnt_one_s) begin
                done_r  <= 1'b1;
                state_r <= ST_FIN;
              end else if (rnw_r) begin
                // Count still includes the byte just read, so 2 means the
                // next read is the final one.
                m_cmd_r <= data_cmd(1'b1, cnt_two_s);
                m_dat_r <= 8'd0;
                m_ws_r  <= 1'b1;
                tmo_r   <= {TMO_W{1'b0}};
                state_r <= ST_ISSUE;
              end else begin
                wr_ready_r <= 1'b1;
                state_r    <= ST_FETCH;
              end
            end
            default: begin
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              state_r <= ST_FIN;
            end
          endcase
        end

        // Master keeps the bus held while the host is slow; no timeout here.
        ST_FETCH: begin
          if (wr_valid) begin
            wr_ready_r <= 1'b0;
            m_cmd_r    <= data_cmd(1'b0, cnt_one_s);
            m_dat_r    <= wr_data;
            m_ws_r     <= 1'b1;
            tmo_r      <= {TMO_W{1'b0}};
            state_r    <= ST_ISSUE;
          end else begin
            state_r <= ST_FETCH;
          end
        end

        ST_FIN: begin
          req_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end

        default: begin
          wr_ready_r  <= 1'b0;
          req_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
